timer_irq_source: RTL and testbench
===================================

Name: timer_irq_source

Overview:
- Memory-mapped timer peripheral that generates the IRQ request the pipeline control unit consumes; it sits on the data-memory bus beside data RAM, decoded in the peripheral window.
- Software programs a reload value and enables counting. The block counts up each clock; on overflow it reloads and latches an interrupt status bit.
- The status bit drives IRQ until software clears it by a bus write, normally from the exception handler.
- Also provides a free-running read-only cycle counter, SYSTICK.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of TH; the other registers are at fixed offsets from it.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address from the MEM stage.
- wdata  input  32  store data.
- MemRd  input  1  load strobe, single cycle.
- MemWr  input  1  store strobe, single cycle; register updated at the next rising edge.
- rdata  output  32  read data, combinational from addr and MemRd.
- IRQ  output  1  interrupt request to control; level, registered.

Behaviour:
- Register map, word aligned; addr[1:0] ignored:
  - +0x00 TH: reload value, R/W.
  - +0x04 TL: current count, R/W.
  - +0x08 TCON: bits[2:0], R/W; bits 31:3 read 0. Bit0 = enable count; bit1 = interrupt enable; bit2 = interrupt status.
  - +0x14 SYSTICK: read-only; writes ignored.
  - Any other address: reads 0, writes ignored.
- Reset (asynchronous, immediate): TH=0, TL=0, TCON=3'b000, SYSTICK=0, IRQ=0. rdata is combinational, so it reads 0 while MemRd is low.
- rdata = selected register when MemRd=1 and addr hits the map; otherwise 32'h0. Zero-latency read of register state before this cycle's edge.
- SYSTICK: increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0 silently.
- Counter state machine, with implicit states IDLE (TCON[0]=0), COUNT, and OVERFLOW as a one-cycle event:
  - IDLE: TL holds.
  - COUNT with TL != 32'hFFFF_FFFF: TL <= TL+1.
  - COUNT with TL == 32'hFFFF_FFFF: overflow. TL <= TH. If TCON[1]=1, TCON[2] <= 1. If TCON[1]=0, the status bit is unchanged.
- Overflow period is (2^32 - TH) cycles after the first reload.
- IRQ <= TCON[2] & TCON[1], registered. It asserts the cycle after the status bit sets and stays high until cleared.
- Software clear: store to TCON with wdata[2]=0.
- Simultaneous events:
  - Store to TL in a counting cycle: the store wins; no increment that cycle.
  - Store to TL with wdata = FFFF_FFFF: overflow occurs the next counting cycle.
  - Store to TH during an overflow cycle: TL reloads the old TH; the new TH applies to the next reload.
  - Store to TCON during an overflow cycle: TCON[1:0] <= wdata[1:0]; TCON[2] <= wdata[2] | (overflow & old TCON[1]). A concurrent overflow is never lost.
  - Store to TCON clearing bit0 during overflow: the overflow still completes (reload, status), then the block is idle.
  - MemRd and MemWr both high to the same register: rdata returns the old value; the write lands at the edge.
- Software may set TCON[2] directly (software interrupt). IRQ follows if TCON[1]=1.
- Reset asserted mid-count or with IRQ high: all state clears immediately. Counting does not resume until software sets TCON[0].

Test Plan:
- Reset check: assert reset mid-count with IRQ=1 -> IRQ=0 immediately; reads of TH, TL, TCON all return 0 after release; SYSTICK restarts at 0.
- Periodic interrupt: TH=FFFF_FFFC, TL=FFFF_FFFC, TCON=3'b011 -> TL counts FFFF_FFFD..FFFF_FFFF, then reloads FFFF_FFFC. TCON reads 3'b111 after the overflow edge; IRQ=1 one cycle later; overflow repeats every 4 cycles.
- Interrupt masked: same setup with TCON=3'b001 -> TL wraps to TH, TCON[2] stays 0, IRQ stays 0.
- Clear vs overflow race: with IRQ=1, write TCON=3'b011 exactly on an overflow cycle -> TCON reads 3'b111 and IRQ stays 1. The same write one cycle later -> TCON=3'b011 and IRQ drops the following cycle.
- TL write priority: counting at TL=0000_0010, store TL=0000_0100 -> next read 0000_0100, then 0000_0101.
- Decode: read BASE+0x0C and BASE+0x20 -> 0. Store to SYSTICK -> value unaffected and still incrementing. Read with MemRd=0 -> rdata=0.

Source files
------------

// File: rtl/timer_irq_source.sv
// rtl/timer_irq_source.sv - memory-mapped reload timer with sticky IRQ status and free-running SYSTICK
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] rdata,
  output logic        IRQ
);

  localparam logic [29:0] TH_WORD      = BASE_ADDR[31:2];
  localparam logic [29:0] TL_WORD      = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] TCON_WORD    = BASE_ADDR[31:2] + 30'd2;
  localparam logic [29:0] SYSTICK_WORD = BASE_ADDR[31:2] + 30'd5;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] systick_q;
  logic        irq_q;

  logic sel_th, sel_tl, sel_tcon, sel_systick;
  logic ovf;
  logic unused_bits;

  assign sel_th      = (addr[31:2] == TH_WORD);
  assign sel_tl      = (addr[31:2] == TL_WORD);
  assign sel_tcon    = (addr[31:2] == TCON_WORD);
  assign sel_systick = (addr[31:2] == SYSTICK_WORD);
  assign unused_bits = ^{addr[1:0], wdata[31:3]};

  assign ovf = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    rdata = 32'h0;
    if (MemRd) begin
      if (sel_th)           rdata = th_q;
      else if (sel_tl)      rdata = tl_q;
      else if (sel_tcon)    rdata = {29'd0, tcon_q};
      else if (sel_systick) rdata = systick_q;
    end
  end

  // Counting first, then stores override; a concurrent overflow still ORs into the status bit.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (ovf) begin
      tl_d = th_q;
      if (tcon_q[1]) tcon_d[2] = 1'b1;
    end else if (tcon_q[0]) begin
      tl_d = tl_q + 32'd1;
    end
    if (MemWr) begin
      if (sel_th)   th_d   = wdata;
      if (sel_tl)   tl_d   = wdata;
      if (sel_tcon) tcon_d = {wdata[2] | (ovf & tcon_q[1]), wdata[1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= 32'h0;
      tl_q      <= 32'h0;
      tcon_q    <= 3'b000;
      systick_q <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_q + 32'd1;
      irq_q     <= tcon_q[2] & tcon_q[1];
    end
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// tb/tb_timer_irq_source.sv - randomized and directed bench for timer_irq_source against a reference model
module tb_timer_irq_source;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE;
  localparam logic [31:0] A_TL = BASE + 32'h4;
  localparam logic [31:0] A_TCON = BASE + 32'h8;
  localparam logic [31:0] A_SYS = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        MemRd, MemWr, IRQ;

  timer_irq_source #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemRd(MemRd), .MemWr(MemWr), .rdata(rdata), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: software-visible registers
  logic [31:0] m_th, m_tl, m_sys;
  logic [2:0]  m_tcon;
  logic        m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_sys = 0; m_tcon = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
    logic [31:0] off;
    off = {a[31:2], 2'b00} - BASE;
    if (!rd) return 32'h0;
    case (off)
      32'h00:  return m_th;
      32'h04:  return m_tl;
      32'h08:  return {29'd0, m_tcon};
      32'h14:  return m_sys;
      default: return 32'h0;
    endcase
  endfunction

  // One rising edge of the timer as software sees it: tick, then the store lands.
  task automatic m_edge(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] off;
    logic        wrap, latch;
    logic [31:0] reload;
    off    = {a[31:2], 2'b00} - BASE;
    wrap   = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    latch  = wrap && m_tcon[1];
    reload = m_th;
    m_irq  = m_tcon[2] && m_tcon[1];
    m_sys  = m_sys + 1;
    if (wrap) m_tl = reload;
    else if (m_tcon[0]) m_tl = m_tl + 1;
    if (latch) m_tcon[2] = 1'b1;
    if (wr) begin
      case (off)
        32'h00: m_th = wd;
        32'h04: m_tl = wd;
        32'h08: m_tcon = {wd[2] | latch, wd[1:0]};
        default: ;
      endcase
    end
  endtask

  task automatic bus_now(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input string tag, output logic [31:0] rv, output logic iv);
    MemRd = rd; MemWr = wr; addr = a; wdata = wd;
    #1;
    rv = rdata;
    iv = IRQ;
    check({tag, "_rdata"}, rdata, m_read(rd, a));
    check({tag, "_irq"}, {31'd0, IRQ}, {31'd0, m_irq});
    @(posedge clk);
    m_edge(wr, a, wd);
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input string tag, output logic [31:0] rv, output logic iv);
    @(negedge clk);
    bus_now(rd, wr, a, wd, tag, rv, iv);
  endtask

  task automatic setup_periodic(input logic [2:0] tcon);
    logic [31:0] rv; logic iv;
    bus(0, 1, A_TCON, 32'h0, "cfg_off", rv, iv);
    bus(0, 1, A_TH, 32'hFFFF_FFFC, "cfg_th", rv, iv);
    bus(0, 1, A_TL, 32'hFFFF_FFFC, "cfg_tl", rv, iv);
    bus(0, 1, A_TCON, {29'd0, tcon}, "cfg_tcon", rv, iv);
  endtask

  // Idle-read until the next edge is an overflow with status already set.
  task automatic wait_ovf_with_irq(input string tag);
    logic [31:0] rv; logic iv;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_tcon[0] && m_tl == 32'hFFFF_FFFF && m_irq) found = 1'b1;
      else bus(1, 0, A_TL, 32'h0, tag, rv, iv);
    end
    check({tag, "_found"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [31:0] rv, exp_tl;
    logic        iv;
    logic [31:0] offs [8];
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h20};

    reset = 1; MemRd = 0; MemWr = 0; addr = 0; wdata = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_rdata_idle", rdata, 32'd0);
    reset = 0;
    bus_now(1, 0, A_SYS, 0, "rst_sys", rv, iv);
    check("rst_sys0", rv, 32'd0);
    bus(1, 0, A_TH, 0, "rst_th", rv, iv);
    bus(1, 0, A_TL, 0, "rst_tl", rv, iv);
    bus(1, 0, A_TCON, 0, "rst_tcon", rv, iv);

    // Periodic interrupt, 4-cycle period
    setup_periodic(3'b011);
    for (int i = 0; i < 9; i++) begin
      exp_tl = 32'hFFFF_FFFC + (i % 4);
      bus(1, 0, A_TL, 0, "per", rv, iv);
      check("per_tl", rv, exp_tl);
    end
    bus(1, 0, A_TCON, 0, "per_tcon", rv, iv);
    check("per_tcon7", rv, 32'd7);

    // Masked: wraps but status stays clear
    setup_periodic(3'b001);
    for (int i = 0; i < 9; i++) begin
      bus(1, 0, A_TCON, 0, "msk", rv, iv);
      if (i >= 2) check("msk_irq0", {31'd0, iv}, 32'd0);
      check("msk_tcon", rv, 32'd1);
    end

    // Clear racing an overflow: overflow wins
    setup_periodic(3'b011);
    wait_ovf_with_irq("race1");
    bus(0, 1, A_TCON, 32'd3, "race1_wr", rv, iv);
    bus(1, 0, A_TCON, 0, "race1_rd", rv, iv);
    check("race1_tcon", rv, 32'd7);
    check("race1_irq", {31'd0, iv}, 32'd1);
    // Same clear one cycle after overflow: IRQ drops the cycle after
    wait_ovf_with_irq("race2");
    bus(1, 0, A_TL, 0, "race2_ovf", rv, iv);
    bus(0, 1, A_TCON, 32'd3, "race2_wr", rv, iv);
    bus(1, 0, A_TCON, 0, "race2_rd", rv, iv);
    check("race2_tcon", rv, 32'd3);
    check("race2_irq_hold", {31'd0, iv}, 32'd1);
    bus(1, 0, A_TCON, 0, "race2_rd2", rv, iv);
    check("race2_irq_drop", {31'd0, iv}, 32'd0);

    // TL store beats increment
    bus(0, 1, A_TCON, 32'd0, "pri_off", rv, iv);
    bus(0, 1, A_TL, 32'h10, "pri_tl", rv, iv);
    bus(0, 1, A_TCON, 32'd1, "pri_en", rv, iv);
    bus(0, 1, A_TL, 32'h100, "pri_wr", rv, iv);
    bus(1, 0, A_TL, 0, "pri_rd", rv, iv);
    check("pri_tl100", rv, 32'h100);
    bus(1, 0, A_TL, 0, "pri_rd2", rv, iv);
    check("pri_tl101", rv, 32'h101);

    // Decode holes, SYSTICK write, MemRd low
    bus(1, 0, BASE + 32'hC, 0, "dec_c", rv, iv);
    check("dec_c0", rv, 32'd0);
    bus(1, 0, BASE + 32'h20, 0, "dec_20", rv, iv);
    check("dec_200", rv, 32'd0);
    bus(0, 1, A_SYS, 32'h1234_5678, "sys_wr", rv, iv);
    bus(1, 0, A_SYS, 0, "sys_rd", rv, iv);
    bus(0, 0, A_TL, 0, "rd_low", rv, iv);
    check("rd_low0", rv, 32'd0);

    // Async reset mid-count with IRQ high
    setup_periodic(3'b011);
    wait_ovf_with_irq("rst2");
    bus(1, 0, A_TL, 0, "rst2_pre", rv, iv);
    @(negedge clk);
    MemWr = 0; MemRd = 1; addr = A_TL;
    #2 reset = 1;
    #1;
    check("rst2_irq_now", {31'd0, IRQ}, 32'd0);
    check("rst2_tl_now", rdata, 32'd0);
    m_reset();
    @(negedge clk);
    reset = 0;
    bus_now(1, 0, A_SYS, 0, "rst2_sys", rv, iv);
    check("rst2_sys0", rv, 32'd0);
    bus(1, 0, A_TCON, 0, "rst2_tcon", rv, iv);
    check("rst2_tcon0", rv, 32'd0);
    bus(1, 0, A_TL, 0, "rst2_tl", rv, iv);
    check("rst2_tl0", rv, 32'd0);

    // Randomized traffic near the wrap point
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, wd;
      logic rd, wr;
      int op;
      op = $urandom_range(0, 9);
      a  = BASE + offs[$urandom_range(0, 7)] + ($urandom & 32'h3);
      rd = ($urandom_range(0, 3) != 0);
      wr = 1'b0;
      wd = $urandom;
      if (op == 0) begin
        wr = 1; a = A_TH;
        wd = ($urandom_range(0, 7) == 0) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF));
      end else if (op == 1) begin
        wr = 1; a = A_TL;
        wd = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      end else if (op == 2) begin
        wr = 1; a = A_TCON;
        wd = $urandom & 32'h7;
        if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
      end else if (op == 3) begin
        wr = 1;
      end
      bus(rd, wr, a, wd, "rnd", rv, iv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
